vga_pattern_gen: RTL and testbench

Parametrised video test-pattern generator for the HDMI/VGA output path. It sits between the VGA timing generator, which supplies pixel coordinates and data-enable, and the TMDS/RGB output stage. It produces RGB565 pixel data with one cycle of latency. There are four selectable patterns: vertical colour bars, horizontal colour bars, checkerboard, and an animated bouncing box. Pattern changes take effect only at frame start, and box motion is frame-synchronous.

---
 rtl/vga_pattern_gen.sv | 206 ++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Video test-pattern generator placed between the VGA timing generator and the
// TMDS/RGB output stage. Produces one RGB565 pixel per clock, one cycle after
// the coordinates arrive.
// Patterns: 0 vertical colour bars, 1 horizontal colour bars, 2 checkerboard,
// 3 bouncing box. The pattern is latched at frame start; the box moves once per
// frame end regardless of the selected pattern.
// Ports:
//   sys_clk_i    pixel clock
//   rst_i        asynchronous active-high reset
//   mode_i       pattern select
//   pix_de_i     active-video qualifier
//   pix_x_i      pixel x coordinate (12 bits)
//   pix_y_i      pixel y coordinate (12 bits)
//   pix_data_o   registered RGB565 pixel
//   pix_de_o     pix_de_i delayed one cycle
//   frame_cnt_o  completed-frame counter (wraps)
module vga_pattern_gen #(
    parameter int H_VALID     = 1920,
    parameter int V_VALID     = 1080,
    parameter int CHECK_SHIFT = 6,
    parameter int BOX_SIZE    = 64,
    parameter int STEP        = 4
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic [1:0]  mode_i,
    input  logic        pix_de_i,
    input  logic [11:0] pix_x_i,
    input  logic [11:0] pix_y_i,
    output logic [15:0] pix_data_o,
    output logic        pix_de_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [15:0] C_RED    = 16'hF800;
    localparam logic [15:0] C_ORANGE = 16'hFC00;
    localparam logic [15:0] C_YELLOW = 16'hFFE0;
    localparam logic [15:0] C_GREEN  = 16'h07E0;
    localparam logic [15:0] C_CYAN   = 16'h07FF;
    localparam logic [15:0] C_BLUE   = 16'h001F;
    localparam logic [15:0] C_PURPLE = 16'hF81F;
    localparam logic [15:0] C_BLACK  = 16'h0000;
    localparam logic [15:0] C_WHITE  = 16'hFFFF;
    localparam logic [15:0] C_GRAY   = 16'hD69A;

    localparam logic [11:0] H_LAST = 12'(H_VALID - 32'sd1);
    localparam logic [11:0] V_LAST = 12'(V_VALID - 32'sd1);
    localparam logic [12:0] H_END  = 13'(H_VALID);
    localparam logic [12:0] V_END  = 13'(V_VALID);
    localparam logic [11:0] H_BAR  = 12'(H_VALID / 32'sd10);
    localparam logic [11:0] V_BAR  = 12'(V_VALID / 32'sd10);
    localparam logic [12:0] X_LIM  = 13'(H_VALID - BOX_SIZE);
    localparam logic [12:0] Y_LIM  = 13'(V_VALID - BOX_SIZE);
    localparam logic [12:0] STEP_W = 13'(STEP);
    localparam logic [12:0] BOX_W  = 13'(BOX_SIZE);

    // Bar number = count of bar boundaries at or below pos; saturates at 9,
    // so the remainder pixels at the far edge fall into the last bar.
    function automatic logic [3:0] bar_index(input logic [11:0] pos, input logic [11:0] width);
        logic [3:0]  idx;
        logic [16:0] thr;
        idx = 4'd0;
        for (int k = 32'sd1; k <= 32'sd9; k++) begin
            thr = 17'(k) * {5'b0_0000, width};
            if ({5'b0_0000, pos} >= thr) begin
                idx = idx + 4'd1;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [15:0] bar_colour(input logic [3:0] idx);
        logic [15:0] c;
        case (idx)
            4'd0:    c = C_RED;
            4'd1:    c = C_ORANGE;
            4'd2:    c = C_YELLOW;
            4'd3:    c = C_GREEN;
            4'd4:    c = C_CYAN;
            4'd5:    c = C_BLUE;
            4'd6:    c = C_PURPLE;
            4'd7:    c = C_BLACK;
            4'd8:    c = C_WHITE;
            default: c = C_GRAY;
        endcase
        return c;
    endfunction

    // Returns {dir, pos} after one frame of motion, clamping at 0 and lim.
    function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dir, input logic [12:0] lim);
        logic [12:0] res;
        if (dir) begin
            if ({1'b0, pos} + STEP_W >= lim) begin
                res = {1'b0, lim[11:0]};
            end else begin
                res = {1'b1, pos + STEP_W[11:0]};
            end
        end else begin
            if ({1'b0, pos} <= STEP_W) begin
                res = {1'b1, 12'd0};
            end else begin
                res = {1'b0, pos - STEP_W[11:0]};
            end
        end
        return res;
    endfunction

    logic [1:0]  mode_r;
    logic [11:0] box_x_r;
    logic [11:0] box_y_r;
    logic        dx_r;
    logic        dy_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] pix_data_r;
    logic        pix_de_r;

    logic        fs_s;
    logic        fe_s;
    logic [1:0]  eff_mode_s;
    logic        in_range_s;
    logic        in_box_s;
    logic [12:0] next_x_s;
    logic [12:0] next_y_s;
    logic [15:0] colour_s;
    logic [15:0] pix_next_s;

    assign fs_s = pix_de_i && (pix_x_i == 12'd0) && (pix_y_i == 12'd0);
    assign fe_s = pix_de_i && (pix_x_i == H_LAST) && (pix_y_i == V_LAST);

    // The frame-start pixel already uses the newly requested mode.
    assign eff_mode_s = fs_s ? mode_i : mode_r;

    assign in_range_s = pix_de_i && ({1'b0, pix_x_i} < H_END) && ({1'b0, pix_y_i} < V_END);

    // Bounds in 13 bits so box_x + BOX_SIZE cannot wrap.
    assign in_box_s = ({1'b0, pix_x_i} >= {1'b0, box_x_r}) &&
                      ({1'b0, pix_x_i} <  {1'b0, box_x_r} + BOX_W) &&
                      ({1'b0, pix_y_i} >= {1'b0, box_y_r}) &&
                      ({1'b0, pix_y_i} <  {1'b0, box_y_r} + BOX_W);

    assign next_x_s = bounce(box_x_r, dx_r, X_LIM);
    assign next_y_s = bounce(box_y_r, dy_r, Y_LIM);

    // Pattern colour selection and blanking outside active video.
    always_comb begin
        colour_s   = C_BLACK;
        pix_next_s = C_BLACK;
        case (eff_mode_s)
            2'd0:    colour_s = bar_colour(bar_index(pix_x_i, H_BAR));
            2'd1:    colour_s = bar_colour(bar_index(pix_y_i, V_BAR));
            2'd2:    colour_s = (pix_x_i[CHECK_SHIFT] ^ pix_y_i[CHECK_SHIFT]) ? C_WHITE : C_BLACK;
            2'd3:    colour_s = in_box_s ? C_WHITE : C_BLUE;
            default: colour_s = C_BLACK;
        endcase
        if (in_range_s) begin
            pix_next_s = colour_s;
        end else begin
            pix_next_s = C_BLACK;
        end
    end

    // Output pipeline register: one cycle of latency for pixel and qualifier.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_data_r <= 16'h0000;
            pix_de_r   <= 1'b0;
        end else begin
            pix_data_r <= pix_next_s;
            pix_de_r   <= pix_de_i;
        end
    end

    // Pattern mode is captured only at frame start.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_r <= 2'd0;
        end else if (fs_s) begin
            mode_r <= mode_i;
        end
    end

    // Box motion and frame counting, advanced once per frame end in every mode.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            box_x_r     <= 12'd0;
            box_y_r     <= 12'd0;
            dx_r        <= 1'b1;
            dy_r        <= 1'b1;
            frame_cnt_r <= 16'd0;
        end else if (fe_s) begin
            dx_r        <= next_x_s[12];
            box_x_r     <= next_x_s[11:0];
            dy_r        <= next_y_s[12];
            box_y_r     <= next_y_s[11:0];
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign pix_data_o  = pix_data_r;
    assign pix_de_o    = pix_de_r;
    assign frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed testbench for vga_pattern_gen.
// Instance a uses the default 1920x1080 geometry for patterns, mode latching,
// blanking and reset; instance b uses a 100x100 frame for box bouncing and the
// frame-counter wrap.
module tb_vga_pattern_gen;

    typedef struct {
        logic        de;
        logic [1:0]  mode;
        logic [11:0] x;
        logic [11:0] y;
        logic [15:0] exp_data;
        logic        exp_de;
        logic [15:0] exp_fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [1:0]  a_mode, b_mode;
    logic        a_de, b_de;
    logic [11:0] a_x, a_y, b_x, b_y;
    logic [15:0] a_data, b_data, a_fc, b_fc;
    logic        a_de_o, b_de_o;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[29];

    always #5 clk = ~clk;

    vga_pattern_gen dut_a (
        .sys_clk_i(clk), .rst_i(rst_a), .mode_i(a_mode), .pix_de_i(a_de),
        .pix_x_i(a_x), .pix_y_i(a_y),
        .pix_data_o(a_data), .pix_de_o(a_de_o), .frame_cnt_o(a_fc)
    );

    vga_pattern_gen #(
        .H_VALID(100), .V_VALID(100), .CHECK_SHIFT(6), .BOX_SIZE(64), .STEP(4)
    ) dut_b (
        .sys_clk_i(clk), .rst_i(rst_b), .mode_i(b_mode), .pix_de_i(b_de),
        .pix_x_i(b_x), .pix_y_i(b_y),
        .pix_data_o(b_data), .pix_de_o(b_de_o), .frame_cnt_o(b_fc)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one pixel into instance b and wait until its output is stable.
    task automatic b_px(input logic de, input logic [11:0] x, input logic [11:0] y, input logic [1:0] m);
        b_de = de; b_x = x; b_y = y; b_mode = m;
        @(negedge clk);
    endtask

    initial begin
        //            de    mode   x         y         data       de    fc
        vecs[0]  = '{1'b1, 2'd0, 12'd0,    12'd0,    16'hF800, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 2'd0, 12'd192,  12'd0,    16'hFC00, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 2'd0, 12'd1919, 12'd0,    16'hD69A, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 2'd0, 12'd5,    12'd0,    16'h0000, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 2'd0, 12'd191,  12'd0,    16'hF800, 1'b1, 16'd0};
        vecs[5]  = '{1'b1, 2'd0, 12'd1727, 12'd5,    16'hFFFF, 1'b1, 16'd0};
        vecs[6]  = '{1'b1, 2'd0, 12'd1728, 12'd5,    16'hD69A, 1'b1, 16'd0};
        vecs[7]  = '{1'b1, 2'd0, 12'd960,  12'd10,   16'h001F, 1'b1, 16'd0};
        vecs[8]  = '{1'b1, 2'd2, 12'd500,  12'd10,   16'hFFE0, 1'b1, 16'd0};  // mid-frame change ignored
        vecs[9]  = '{1'b1, 2'd2, 12'd600,  12'd20,   16'h07E0, 1'b1, 16'd0};
        vecs[10] = '{1'b1, 2'd2, 12'd4095, 12'd0,    16'h0000, 1'b1, 16'd0};  // x out of range
        vecs[11] = '{1'b1, 2'd2, 12'd0,    12'd0,    16'h0000, 1'b1, 16'd0};  // fs latches checker
        vecs[12] = '{1'b1, 2'd2, 12'd64,   12'd0,    16'hFFFF, 1'b1, 16'd0};
        vecs[13] = '{1'b1, 2'd2, 12'd64,   12'd64,   16'h0000, 1'b1, 16'd0};
        vecs[14] = '{1'b1, 2'd2, 12'd130,  12'd70,   16'hFFFF, 1'b1, 16'd0};
        vecs[15] = '{1'b1, 2'd1, 12'd10,   12'd10,   16'h0000, 1'b1, 16'd0};  // still checker
        vecs[16] = '{1'b1, 2'd1, 12'd0,    12'd0,    16'hF800, 1'b1, 16'd0};  // fs latches hbars
        vecs[17] = '{1'b1, 2'd1, 12'd5,    12'd108,  16'hFC00, 1'b1, 16'd0};
        vecs[18] = '{1'b1, 2'd1, 12'd5,    12'd1079, 16'hD69A, 1'b1, 16'd0};
        vecs[19] = '{1'b1, 2'd1, 12'd5,    12'd1080, 16'h0000, 1'b1, 16'd0};
        vecs[20] = '{1'b1, 2'd1, 12'd5,    12'd540,  16'h001F, 1'b1, 16'd0};
        vecs[21] = '{1'b0, 2'd1, 12'd5,    12'd108,  16'h0000, 1'b0, 16'd0};
        vecs[22] = '{1'b1, 2'd1, 12'd5,    12'd971,  16'hFFFF, 1'b1, 16'd0};
        vecs[23] = '{1'b1, 2'd1, 12'd1919, 12'd1079, 16'hD69A, 1'b1, 16'd1};  // fe: counter, box -> (4,4)
        vecs[24] = '{1'b1, 2'd3, 12'd0,    12'd0,    16'h001F, 1'b1, 16'd1};
        vecs[25] = '{1'b1, 2'd3, 12'd4,    12'd4,    16'hFFFF, 1'b1, 16'd1};
        vecs[26] = '{1'b1, 2'd3, 12'd67,   12'd4,    16'hFFFF, 1'b1, 16'd1};
        vecs[27] = '{1'b1, 2'd3, 12'd68,   12'd4,    16'h001F, 1'b1, 16'd1};
        vecs[28] = '{1'b1, 2'd3, 12'd4,    12'd68,   16'h001F, 1'b1, 16'd1};

        rst_a = 1'b1; rst_b = 1'b1;
        a_de = 1'b0; a_mode = 2'd0; a_x = 12'd0; a_y = 12'd0;
        b_de = 1'b0; b_mode = 2'd0; b_x = 12'd0; b_y = 12'd0;
        #3;
        check("reset data", a_data, 16'h0000);
        check("reset de", {15'd0, a_de_o}, 16'h0000);
        check("reset fc", a_fc, 16'h0000);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Table-driven vectors on instance a.
        for (int i = 0; i < 29; i++) begin
            a_de = vecs[i].de; a_mode = vecs[i].mode; a_x = vecs[i].x; a_y = vecs[i].y;
            @(negedge clk);
            check($sformatf("vec%0d data", i), a_data, vecs[i].exp_data);
            check($sformatf("vec%0d de", i), {15'd0, a_de_o}, {15'd0, vecs[i].exp_de});
            check($sformatf("vec%0d fc", i), a_fc, vecs[i].exp_fc);
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        a_de = 1'b1; a_mode = 2'd3; a_x = 12'd4; a_y = 12'd4;
        @(negedge clk);
        check("pre-reset box", a_data, 16'hFFFF);
        #2;
        rst_a = 1'b1;
        #1;
        check("async rst data", a_data, 16'h0000);
        check("async rst de", {15'd0, a_de_o}, 16'h0000);
        check("async rst fc", a_fc, 16'h0000);
        @(negedge clk);
        rst_a = 1'b0;
        // Released mid-frame: mode 0 until the next frame start.
        a_de = 1'b1; a_mode = 2'd3; a_x = 12'd192; a_y = 12'd0;
        @(negedge clk);
        check("post-reset mode0", a_data, 16'hFC00);
        check("post-reset de", {15'd0, a_de_o}, 16'h0001);
        a_de = 1'b0;

        // Instance b: box bouncing in a 100x100 frame, limit 36.
        b_px(1'b1, 12'd0, 12'd0, 2'd3);
        check("b origin box", b_data, 16'hFFFF);
        for (int f = 0; f < 9; f++) b_px(1'b1, 12'd99, 12'd99, 2'd3);
        check("b fc 9", b_fc, 16'd9);
        b_px(1'b1, 12'd0, 12'd0, 2'd3);
        check("b f10 (0,0)", b_data, 16'h001F);
        b_px(1'b1, 12'd36, 12'd36, 2'd3);
        check("b f10 (36,36)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd35, 12'd36, 2'd3);
        check("b f10 (35,36)", b_data, 16'h001F);
        b_px(1'b1, 12'd99, 12'd98, 2'd3);
        check("b f10 (99,98)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd99, 12'd99, 2'd3);
        check("b f10 fe pixel", b_data, 16'hFFFF);
        check("b fc 10", b_fc, 16'd10);
        // Box has reversed: now at (32,32).
        b_px(1'b1, 12'd32, 12'd32, 2'd3);
        check("b (32,32)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd31, 12'd32, 2'd3);
        check("b (31,32)", b_data, 16'h001F);
        b_px(1'b1, 12'd95, 12'd95, 2'd3);
        check("b (95,95)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd96, 12'd32, 2'd3);
        check("b (96,32)", b_data, 16'h001F);

        // Counter wrap in mode 0; box keeps moving.
        b_px(1'b1, 12'd0, 12'd0, 2'd0);
        check("b mode0 red", b_data, 16'hF800);
        for (int f = 0; f < 65525; f++) b_px(1'b1, 12'd99, 12'd99, 2'd0);
        check("b fc ffff", b_fc, 16'hFFFF);
        b_px(1'b1, 12'd99, 12'd99, 2'd0);
        check("b fc wrap", b_fc, 16'h0000);
        // 65536 frames total; bounce period is 18 frames, 65536 mod 18 = 16,
        // i.e. 7 steps down from 36: box at (8,8).
        b_px(1'b1, 12'd0, 12'd0, 2'd3);
        check("b wrap (0,0)", b_data, 16'h001F);
        b_px(1'b1, 12'd8, 12'd8, 2'd3);
        check("b wrap (8,8)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd7, 12'd8, 2'd3);
        check("b wrap (7,8)", b_data, 16'h001F);
        b_px(1'b1, 12'd71, 12'd71, 2'd3);
        check("b wrap (71,71)", b_data, 16'hFFFF);
        b_px(1'b1, 12'd72, 12'd8, 2'd3);
        check("b wrap (72,8)", b_data, 16'h001F);
        b_px(1'b0, 12'd8, 12'd8, 2'd3);
        check("b de0", b_data, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
